// File: rtl/cp0_except_if.sv
// cp0_except_if: MEM-stage exception flags, MTC0/MFC0 port and CP0 state
// outputs exchanged between the pipeline (master) and cp0_except_unit (slave).
interface cp0_except_if;
   logic        mem_valid;
   logic [7:0]  mem_exc_flags;
   logic [31:0] mem_pc;
   logic [31:0] mem_badvaddr;
   logic        mem_in_delay_slot;
   logic [5:0]  int_hw;
   logic        cp0_we;
   logic [4:0]  cp0_waddr;
   logic [31:0] cp0_wdata;
   logic [4:0]  cp0_raddr;
   logic [31:0] cp0_rdata;
   logic [31:0] except_type_cp0;
   logic [31:0] cp0_epc;
   logic [31:0] cp0_status;
   logic [31:0] cp0_cause;

   modport master (
      output mem_valid, mem_exc_flags, mem_pc, mem_badvaddr, mem_in_delay_slot,
      output int_hw, cp0_we, cp0_waddr, cp0_wdata, cp0_raddr,
      input  cp0_rdata, except_type_cp0, cp0_epc, cp0_status, cp0_cause
   );

   modport slave (
      input  mem_valid, mem_exc_flags, mem_pc, mem_badvaddr, mem_in_delay_slot,
      input  int_hw, cp0_we, cp0_waddr, cp0_wdata, cp0_raddr,
      output cp0_rdata, except_type_cp0, cp0_epc, cp0_status, cp0_cause
   );
endinterface

// File: rtl/cp0_except_unit.sv
// cp0_except_unit: coprocessor-0 register file and MEM-stage exception
// prioritizer. Selects one exception per cycle, reports it combinationally and
// commits Status/Cause/EPC/BadVAddr on the next rising edge.
// Optional feature: define CP0_TIMER_INT_EN to enable the Count/Compare timer
// interrupt (TI); without it Count and Compare are plain storage and TI is 0.
module cp0_except_unit #(
   parameter logic [31:0] RESET_STATUS = 32'h0040_0000
) (
   input logic        clk,
   input logic        rst,
   cp0_except_if.slave bus
);

   localparam logic [4:0]  REG_BADVADDR = 5'd8;
   localparam logic [4:0]  REG_COUNT    = 5'd9;
   localparam logic [4:0]  REG_COMPARE  = 5'd11;
   localparam logic [4:0]  REG_STATUS   = 5'd12;
   localparam logic [4:0]  REG_CAUSE    = 5'd13;
   localparam logic [4:0]  REG_EPC      = 5'd14;
   localparam logic [31:0] STATUS_WMASK = 32'h0000_ff03;

   logic [31:0] badvaddr_q;
   logic [31:0] count_q;
   logic [31:0] compare_q;
   logic [31:0] status_q;
   logic [31:0] epc_q;
   logic        cause_bd_q;
   logic [4:0]  cause_exc_q;
   logic [5:0]  ip_hw_q;
   logic [1:0]  ip_sw_q;
   logic        ti;

   logic [7:0]  cause_ip;
   logic [31:0] cause_val;
   logic        irq_pending;
   logic [31:0] except_type;
   logic [4:0]  exc_code;
   logic        take_exc;
   logic        take_eret;
   logic        load_badv_pc;
   logic        load_badv_data;
   logic        wr_count;
   logic        wr_compare;
   logic        wr_status;
   logic        wr_cause;
   logic        wr_epc;
   logic [31:0] rdata;

   assign wr_count   = bus.cp0_we && (bus.cp0_waddr == REG_COUNT);
   assign wr_compare = bus.cp0_we && (bus.cp0_waddr == REG_COMPARE);
   assign wr_status  = bus.cp0_we && (bus.cp0_waddr == REG_STATUS);
   assign wr_cause   = bus.cp0_we && (bus.cp0_waddr == REG_CAUSE);
   assign wr_epc     = bus.cp0_we && (bus.cp0_waddr == REG_EPC);

   // IP[7] also carries the timer interrupt; IP[1:0] are the software bits.
   assign cause_ip    = {ip_hw_q[5] | ti, ip_hw_q[4:0], ip_sw_q};
   assign cause_val   = {cause_bd_q, ti, 14'd0, cause_ip, 1'b0, cause_exc_q, 2'b00};
   assign irq_pending = bus.mem_valid && status_q[0] && !status_q[1] &&
                        ((cause_ip & status_q[15:8]) != 8'h00);

   // Fixed-priority selection: interrupt first, then the flag bits in order
   // (bit 0 is highest priority); bubbles contribute no flags.
   always_comb begin
      except_type    = 32'h0;
      exc_code       = 5'h00;
      take_exc       = 1'b0;
      take_eret      = 1'b0;
      load_badv_pc   = 1'b0;
      load_badv_data = 1'b0;
      if (irq_pending) begin
         except_type = 32'h1;
         exc_code    = 5'h00;
         take_exc    = 1'b1;
      end else if (bus.mem_valid) begin
         if (bus.mem_exc_flags[0]) begin
            except_type  = 32'h4;
            exc_code     = 5'h04;
            take_exc     = 1'b1;
            load_badv_pc = 1'b1;
         end else if (bus.mem_exc_flags[1]) begin
            except_type = 32'ha;
            exc_code    = 5'h0a;
            take_exc    = 1'b1;
         end else if (bus.mem_exc_flags[2]) begin
            except_type = 32'hc;
            exc_code    = 5'h0c;
            take_exc    = 1'b1;
         end else if (bus.mem_exc_flags[3]) begin
            except_type = 32'h8;
            exc_code    = 5'h08;
            take_exc    = 1'b1;
         end else if (bus.mem_exc_flags[4]) begin
            except_type = 32'h9;
            exc_code    = 5'h09;
            take_exc    = 1'b1;
         end else if (bus.mem_exc_flags[5]) begin
            except_type = 32'he;
            take_eret   = 1'b1;
         end else if (bus.mem_exc_flags[6]) begin
            except_type    = 32'h4;
            exc_code       = 5'h04;
            take_exc       = 1'b1;
            load_badv_data = 1'b1;
         end else if (bus.mem_exc_flags[7]) begin
            except_type    = 32'h5;
            exc_code       = 5'h05;
            take_exc       = 1'b1;
            load_badv_data = 1'b1;
         end
      end
   end

   // Status/Cause/EPC/BadVAddr: MTC0 first, the exception update last so it
   // overrides exactly the fields it touches.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         status_q    <= RESET_STATUS;
         epc_q       <= 32'h0;
         badvaddr_q  <= 32'h0;
         cause_bd_q  <= 1'b0;
         cause_exc_q <= 5'h00;
         ip_hw_q     <= 6'h00;
         ip_sw_q     <= 2'b00;
      end else begin
         ip_hw_q <= bus.int_hw;
         if (wr_status) begin
            status_q <= (status_q & ~STATUS_WMASK) | (bus.cp0_wdata & STATUS_WMASK);
         end
         if (wr_cause) begin
            ip_sw_q <= bus.cp0_wdata[9:8];
         end
         if (wr_epc) begin
            epc_q <= bus.cp0_wdata;
         end
         if (take_exc) begin
            cause_exc_q <= exc_code;
            status_q[1] <= 1'b1;
            if (!status_q[1]) begin
               epc_q      <= bus.mem_in_delay_slot ? (bus.mem_pc - 32'd4) : bus.mem_pc;
               cause_bd_q <= bus.mem_in_delay_slot;
            end
            if (load_badv_pc) begin
               badvaddr_q <= bus.mem_pc;
            end else if (load_badv_data) begin
               badvaddr_q <= bus.mem_badvaddr;
            end
         end else if (take_eret) begin
            status_q[1] <= 1'b0;
         end
      end
   end

`ifdef CP0_TIMER_INT_EN
   logic tick_q;
   logic ti_q;

   // Count advances every second cycle; TI latches on a Compare match right
   // after an increment and is cleared by any Compare write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q   <= 32'h0;
         compare_q <= 32'h0;
         tick_q    <= 1'b0;
         ti_q      <= 1'b0;
      end else begin
         if (wr_compare) begin
            compare_q <= bus.cp0_wdata;
         end
         if (wr_count) begin
            count_q <= bus.cp0_wdata;
            tick_q  <= 1'b0;
         end else begin
            tick_q <= ~tick_q;
            if (tick_q) begin
               count_q <= count_q + 32'd1;
            end
         end
         if (wr_compare) begin
            ti_q <= 1'b0;
         end else if (!wr_count && tick_q && ((count_q + 32'd1) == compare_q)) begin
            ti_q <= 1'b1;
         end
      end
   end

   assign ti = ti_q;
`else
   // Without the timer, Count and Compare are plain MTC0/MFC0 storage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q   <= 32'h0;
         compare_q <= 32'h0;
      end else begin
         if (wr_count) begin
            count_q <= bus.cp0_wdata;
         end
         if (wr_compare) begin
            compare_q <= bus.cp0_wdata;
         end
      end
   end

   assign ti = 1'b0;
`endif

   // MFC0 read mux; unimplemented register numbers read as zero.
   always_comb begin
      rdata = 32'h0;
      case (bus.cp0_raddr)
         REG_BADVADDR: rdata = badvaddr_q;
         REG_COUNT:    rdata = count_q;
         REG_COMPARE:  rdata = compare_q;
         REG_STATUS:   rdata = status_q;
         REG_CAUSE:    rdata = cause_val;
         REG_EPC:      rdata = epc_q;
         default:      rdata = 32'h0;
      endcase
   end

   assign bus.cp0_rdata       = rdata;
   assign bus.except_type_cp0 = except_type;
   assign bus.cp0_epc         = wr_epc ? bus.cp0_wdata : epc_q;
   assign bus.cp0_status      = status_q;
   assign bus.cp0_cause       = cause_val;

endmodule

// File: tb/tb_cp0_except_unit.sv
// tb_cp0_except_unit: directed plus randomized stimulus for cp0_except_unit.
// A driver pushes the expected response of each cycle into a queue; a monitor
// on the falling edge pops and compares against the DUT outputs.
module tb_cp0_except_unit;

`ifdef CP0_TIMER_INT_EN
   localparam bit TIMER = 1'b1;
`else
   localparam bit TIMER = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;

   cp0_except_if bus ();

   cp0_except_unit #(.RESET_STATUS(32'h0040_0000)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] etype;
      logic [31:0] epc;
      logic [31:0] rdata;
      logic [31:0] status;
      logic [31:0] cause;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Exception table in priority order of the flag bits.
   int type_tab[8] = '{32'h4, 32'ha, 32'hc, 32'h8, 32'h9, 32'he, 32'h4, 32'h5};
   int code_tab[8] = '{4, 10, 12, 8, 9, 0, 4, 5};

   // Reference model state (architectural view).
   logic [31:0] m_status, m_epc, m_badv, m_compare, m_cbase;
   logic        m_bd, m_ti;
   logic [4:0]  m_exc;
   logic [5:0]  m_iphw;
   logic [1:0]  m_ipsw;
   int          m_elapsed;

   // Inputs of the cycle in flight, kept for the model update at the edge.
   logic        c_v, c_ds, c_we;
   logic [7:0]  c_flags;
   logic [31:0] c_pc, c_badv, c_wdata;
   logic [5:0]  c_int;
   logic [4:0]  c_waddr;
   logic [31:0] c_etype;
   int          c_sel;

   task automatic modelReset();
      m_status  = 32'h0040_0000;
      m_epc     = 0;
      m_badv    = 0;
      m_compare = 0;
      m_cbase   = 0;
      m_bd      = 0;
      m_ti      = 0;
      m_exc     = 0;
      m_iphw    = 0;
      m_ipsw    = 0;
      m_elapsed = 0;
   endtask

   function automatic logic [31:0] mCount();
      return m_cbase + 32'(m_elapsed / 2);
   endfunction

   function automatic logic [31:0] mCause();
      logic [7:0] ip;
      ip = {m_iphw[5] | m_ti, m_iphw[4:0], m_ipsw};
      return {m_bd, m_ti, 14'd0, ip, 1'b0, m_exc, 2'b00};
   endfunction

   function automatic logic [31:0] mRead(input logic [4:0] a);
      case (a)
         5'd8:    return m_badv;
         5'd9:    return mCount();
         5'd11:   return m_compare;
         5'd12:   return m_status;
         5'd13:   return mCause();
         5'd14:   return m_epc;
         default: return 32'h0;
      endcase
   endfunction

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs and queue the response the model predicts.
   task automatic applyStimulus(input logic v, input logic [7:0] flags, input logic [31:0] pc,
                                input logic [31:0] badv, input logic ds, input logic [5:0] inthw,
                                input logic we, input logic [4:0] waddr, input logic [31:0] wdata,
                                input logic [4:0] raddr);
      exp_t        e;
      logic [31:0] cause;
      logic        irq;
      bus.mem_valid         = v;
      bus.mem_exc_flags     = flags;
      bus.mem_pc            = pc;
      bus.mem_badvaddr      = badv;
      bus.mem_in_delay_slot = ds;
      bus.int_hw            = inthw;
      bus.cp0_we            = we;
      bus.cp0_waddr         = waddr;
      bus.cp0_wdata         = wdata;
      bus.cp0_raddr         = raddr;
      c_v = v; c_flags = flags; c_pc = pc; c_badv = badv; c_ds = ds;
      c_int = inthw; c_we = we; c_waddr = waddr; c_wdata = wdata;
      cause = mCause();
      irq   = v && m_status[0] && !m_status[1] && ((cause[15:8] & m_status[15:8]) != 8'h00);
      c_sel   = -1;
      c_etype = 32'h0;
      if (irq) begin
         c_etype = 32'h1;
      end else if (v) begin
         for (int i = 0; i < 8; i++) begin
            if (flags[i] && c_sel < 0) begin
               c_sel   = i;
               c_etype = type_tab[i];
            end
         end
      end
      e.etype  = c_etype;
      e.epc    = (we && waddr == 5'd14) ? wdata : m_epc;
      e.rdata  = mRead(raddr);
      e.status = m_status;
      e.cause  = cause;
      exp_q.push_back(e);
   endtask

   // Advance one clock and apply the architectural effects of the cycle.
   task automatic stepClock();
      logic old_exl;
      @(posedge clk);
      old_exl = m_status[1];
      m_iphw  = c_int;
      if (c_we) begin
         case (c_waddr)
            5'd9:    begin m_cbase = c_wdata; m_elapsed = 0; end
            5'd11:   begin m_compare = c_wdata; m_ti = 1'b0; end
            5'd12:   m_status = (m_status & ~32'h0000_ff03) | (c_wdata & 32'h0000_ff03);
            5'd13:   m_ipsw = c_wdata[9:8];
            5'd14:   m_epc = c_wdata;
            default: ;
         endcase
      end
      if (TIMER && !(c_we && c_waddr == 5'd9)) begin
         m_elapsed++;
         if ((m_elapsed % 2 == 0) && !(c_we && c_waddr == 5'd11) && (mCount() == m_compare))
            m_ti = 1'b1;
      end
      if (c_etype == 32'he) begin
         m_status[1] = 1'b0;
      end else if (c_etype != 32'h0) begin
         m_exc = (c_etype == 32'h1) ? 5'd0 : 5'(code_tab[c_sel]);
         if (!old_exl) begin
            m_epc = c_ds ? c_pc - 32'd4 : c_pc;
            m_bd  = c_ds;
         end
         m_status[1] = 1'b1;
         if (c_sel == 0) m_badv = c_pc;
         else if (c_sel == 6 || c_sel == 7) m_badv = c_badv;
      end
      #1;
   endtask

   task automatic idle(input logic [4:0] raddr);
      applyStimulus(1'b0, 8'h00, 32'h0, 32'h0, 1'b0, 6'h00, 1'b0, 5'd0, 32'h0, raddr);
   endtask

   task automatic randomCycle();
      logic [7:0]  flags;
      logic [4:0]  waddr, raddr;
      logic [4:0]  regs[7];
      int          r;
      regs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0};
      regs[6] = 5'($urandom_range(31));
      r = $urandom_range(9);
      if (r < 4) flags = 8'h00;
      else if (r < 8) flags = 8'h01 << $urandom_range(7);
      else flags = 8'($urandom);
      waddr = regs[$urandom_range(6)];
      raddr = regs[$urandom_range(6)];
      applyStimulus(($urandom_range(3) != 0), flags, {$urandom, 2'b00} ,
                    $urandom, 1'($urandom), ($urandom_range(3) == 0) ? 6'($urandom) : 6'h00,
                    ($urandom_range(3) == 0), waddr, $urandom, raddr);
      stepClock();
   endtask

   // Monitor: one queued expectation is checked per cycle on the falling edge.
   task automatic checkOutput(input exp_t e);
      cmp("except_type", bus.except_type_cp0, e.etype);
      cmp("cp0_epc", bus.cp0_epc, e.epc);
      cmp("cp0_rdata", bus.cp0_rdata, e.rdata);
      cmp("cp0_status", bus.cp0_status, e.status);
      cmp("cp0_cause", bus.cp0_cause, e.cause);
   endtask

   always @(negedge clk) begin
      if (!rst && exp_q.size() != 0) begin
         checkOutput(exp_q.pop_front());
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired actual=running expected=finished");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst = 1'b1;
      bus.mem_valid = 0; bus.mem_exc_flags = 0; bus.mem_pc = 0; bus.mem_badvaddr = 0;
      bus.mem_in_delay_slot = 0; bus.int_hw = 0; bus.cp0_we = 0; bus.cp0_waddr = 0;
      bus.cp0_wdata = 0; bus.cp0_raddr = 0;
      modelReset();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset values.
      idle(5'd12); #2 cmp("reset_status", bus.cp0_rdata, 32'h0040_0000);
      cmp("reset_type", bus.except_type_cp0, 32'h0); stepClock();
      idle(5'd13); #2 cmp("reset_cause", bus.cp0_rdata, 32'h0); stepClock();

      // Syscall outside a delay slot.
      applyStimulus(1, 8'h08, 32'hbfc0_0100, 0, 0, 0, 0, 0, 0, 5'd14);
      #2 cmp("syscall_type", bus.except_type_cp0, 32'h8); stepClock();
      idle(5'd14); #2 cmp("syscall_epc", bus.cp0_rdata, 32'hbfc0_0100);
      cmp("syscall_exccode", 32'(bus.cp0_cause[6:2]), 32'h8);
      cmp("syscall_exl", 32'(bus.cp0_status[1]), 32'h1); stepClock();
      applyStimulus(1, 8'h20, 32'hbfc0_0104, 0, 0, 0, 0, 0, 0, 5'd12); stepClock();

      // Store address error in a delay slot.
      applyStimulus(1, 8'h80, 32'hbfc0_0204, 32'h8000_0003, 1, 0, 0, 0, 0, 5'd8);
      #2 cmp("ades_type", bus.except_type_cp0, 32'h5); stepClock();
      idle(5'd8); #2 cmp("ades_badvaddr", bus.cp0_rdata, 32'h8000_0003);
      cmp("ades_epc", bus.cp0_epc, 32'hbfc0_0200);
      cmp("ades_bd", 32'(bus.cp0_cause[31]), 32'h1); stepClock();
      applyStimulus(1, 8'h20, 32'hbfc0_0208, 0, 0, 0, 0, 0, 0, 5'd12); stepClock();

      // Interrupt outranks overflow.
      applyStimulus(0, 0, 0, 0, 0, 6'h01, 1, 5'd12, 32'h0000_0401, 5'd12); stepClock();
      applyStimulus(1, 8'h04, 32'hbfc0_0300, 0, 0, 6'h01, 0, 0, 0, 5'd12);
      #2 cmp("irq_type", bus.except_type_cp0, 32'h1);
      cmp("irq_status", bus.cp0_rdata, 32'h0040_0401); stepClock();
      idle(5'd13); #2 cmp("irq_exccode", 32'(bus.cp0_cause[6:2]), 32'h0); stepClock();

      // MTC0 EPC with eret in the same cycle.
      applyStimulus(1, 8'h20, 32'hbfc0_0400, 0, 0, 0, 1, 5'd14, 32'hbfc0_0380, 5'd12);
      #2 cmp("bypass_epc", bus.cp0_epc, 32'hbfc0_0380);
      cmp("bypass_type", bus.except_type_cp0, 32'he); stepClock();
      idle(5'd12); #2 cmp("eret_exl", 32'(bus.cp0_status[1]), 32'h0); stepClock();

`ifdef CP0_TIMER_INT_EN
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd11, 32'd4, 5'd11); stepClock();
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd9, 32'd0, 5'd9); stepClock();
      repeat (8) begin idle(5'd9); stepClock(); end
      idle(5'd13); #2 cmp("timer_ti", 32'(bus.cp0_cause[30]), 32'h1);
      cmp("timer_ip7", 32'(bus.cp0_cause[15]), 32'h1); stepClock();
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd11, 32'd1000, 5'd13); stepClock();
      idle(5'd13); #2 cmp("timer_ti_clear", 32'(bus.cp0_cause[30]), 32'h0); stepClock();
`endif

      repeat (400) randomCycle();

      // Reset while an exception is being presented discards its update.
      bus.mem_valid = 1; bus.mem_exc_flags = 8'h08; bus.mem_pc = 32'hbfc0_0500;
      bus.cp0_we = 0;
      #2 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      modelReset();
      idle(5'd12); #2 cmp("rst_discard_status", bus.cp0_rdata, 32'h0040_0000);
      cmp("rst_discard_epc", bus.cp0_epc, 32'h0); stepClock();

      repeat (150) randomCycle();

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain actual=%0d expected=0 pending", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
